contador_regressivo_segundos: RTL and testbench

CONTADOR_REGRESSIVO_SEGUNDOS -- requirements
Module: contador_regressivo_segundos

---
 rtl/contador_regressivo_segundos_pkg.sv | 23 ++
 rtl/contador_regressivo_segundos_digito.sv | 35 +++
 rtl/contador_regressivo_segundos.sv | 129 ++++++++++++
 tb/tb_contador_regressivo_segundos.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_regressivo_segundos_pkg.sv
// Shared definitions for the seconds countdown: FSM states,
// BCD constants and the preset clamp helper.
package contador_regressivo_segundos_pkg;

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [3:0] ZERO_BCD = 4'd0;
  localparam int MAX_UNIDADE_DEF = 9;
  localparam int MAX_DEZENA_DEF  = 5;

  function automatic logic [3:0] limitaBcd(
    input logic [3:0] valor,
    input logic [3:0] limite
  );
    return (valor > limite) ? limite : valor;
  endfunction

endpackage

// File: rtl/contador_regressivo_segundos_digito.sv
// One BCD down-counting digit with load, enable and borrow out.
// Borrow is high when enabled while the digit sits at zero.
module digito_regressivo
  import contador_regressivo_segundos_pkg::*;
#(
  parameter int MAX = MAX_UNIDADE_DEF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       carregar,
  input  logic [3:0] valorCarga,
  input  logic       habilitar,
  output logic [3:0] q,
  output logic       emprestimo
);

  localparam logic [3:0] MAX_BCD = 4'(MAX);

  logic emZero;

  assign emZero     = (q == ZERO_BCD);
  assign emprestimo = habilitar && emZero;

  // load has priority over counting; zero wraps to the digit max
  always_ff @(posedge clk) begin
    if (clear) begin
      q <= ZERO_BCD;
    end else if (carregar) begin
      q <= limitaBcd(valorCarga, MAX_BCD);
    end else if (habilitar) begin
      q <= emZero ? MAX_BCD : q - 4'd1;
    end
  end

endmodule

// File: rtl/contador_regressivo_segundos.sv
// Seconds countdown (MM:SS seconds half) with borrow to minutes.
// Optional RECARGA_AUTOMATICA_EN: reload last preset at end.
module contador_regressivo_segundos
  import contador_regressivo_segundos_pkg::*;
#(
  parameter int MAX_DEZENA  = MAX_DEZENA_DEF,
  parameter int MAX_UNIDADE = MAX_UNIDADE_DEF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       carregar,
  input  logic [3:0] presetUnidade,
  input  logic [3:0] presetDezena,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       minutosZero,
  output logic [3:0] qUnidade,
  output logic [3:0] qDezena,
  output logic       emprestimo,
  output logic       fim
);

  estado_t estado;

  logic       cargaOk;
  logic       tickAtivo;
  logic       zeroAtual;
  logic       fimCond;
  logic       contaEn;
  logic       bUnidade;
  logic       bDezena;
  logic       carregaDig;
  logic [3:0] cargaUnidade;
  logic [3:0] cargaDezena;

  assign cargaOk   = carregar && (estado != CONTANDO);
  assign tickAtivo = tick && (estado == CONTANDO);
  assign zeroAtual = (qUnidade == ZERO_BCD)
                  && (qDezena == ZERO_BCD);
  assign fimCond   = tickAtivo && zeroAtual && minutosZero;
  assign contaEn   = tickAtivo && !fimCond;

`ifdef RECARGA_AUTOMATICA_EN
  logic [3:0] guardaUnidade;
  logic [3:0] guardaDezena;

  // remember the clamped preset so the end of count can reload it
  always_ff @(posedge clk) begin
    if (clear) begin
      guardaUnidade <= ZERO_BCD;
      guardaDezena  <= ZERO_BCD;
    end else if (cargaOk) begin
      guardaUnidade <= limitaBcd(presetUnidade, 4'(MAX_UNIDADE));
      guardaDezena  <= limitaBcd(presetDezena, 4'(MAX_DEZENA));
    end
  end

  assign carregaDig   = cargaOk || fimCond;
  assign cargaUnidade = cargaOk ? presetUnidade : guardaUnidade;
  assign cargaDezena  = cargaOk ? presetDezena : guardaDezena;
`else
  assign carregaDig   = cargaOk;
  assign cargaUnidade = presetUnidade;
  assign cargaDezena  = presetDezena;
`endif

  digito_regressivo #(
    .MAX(MAX_UNIDADE)
  ) uUnidade (
    .clk       (clk),
    .clear     (clear),
    .carregar  (carregaDig),
    .valorCarga(cargaUnidade),
    .habilitar (contaEn),
    .q         (qUnidade),
    .emprestimo(bUnidade)
  );

  digito_regressivo #(
    .MAX(MAX_DEZENA)
  ) uDezena (
    .clk       (clk),
    .clear     (clear),
    .carregar  (carregaDig),
    .valorCarga(cargaDezena),
    .habilitar (bUnidade),
    .q         (qDezena),
    .emprestimo(bDezena)
  );

  // control FSM; borrow out of the tens digit means 00 -> max wrap
  always_ff @(posedge clk) begin
    if (clear) begin
      estado     <= PARADO;
      emprestimo <= 1'b0;
      fim        <= 1'b0;
    end else begin
      emprestimo <= bDezena;
      fim        <= 1'b0;
      if (cargaOk) begin
        estado <= PARADO;
      end else begin
        unique case (estado)
          PARADO, PAUSADO: begin
            if (iniciar && !pausar) estado <= CONTANDO;
          end
          CONTANDO: begin
            if (fimCond) begin
              fim <= 1'b1;
`ifdef RECARGA_AUTOMATICA_EN
              if (pausar) estado <= PAUSADO;
`else
              estado <= FIM;
`endif
            end else if (pausar) begin
              estado <= PAUSADO;
            end
          end
          FIM: begin
            fim <= 1'b1;
          end
          default: estado <= PARADO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_regressivo_segundos.sv
// Bench for contador_regressivo_segundos: directed scenarios plus
// random traffic against a seconds-as-integer reference model.
module tb_contador_regressivo_segundos;
  import contador_regressivo_segundos_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       tick = 1'b0;
  logic       carregar = 1'b0;
  logic [3:0] presetUnidade = 4'd0;
  logic [3:0] presetDezena = 4'd0;
  logic       iniciar = 1'b0;
  logic       pausar = 1'b0;
  logic       minutosZero = 1'b0;
  logic [3:0] qUnidade;
  logic [3:0] qDezena;
  logic       emprestimo;
  logic       fim;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_regressivo_segundos dut (
    .clk          (clk),
    .clear        (clear),
    .tick         (tick),
    .carregar     (carregar),
    .presetUnidade(presetUnidade),
    .presetDezena (presetDezena),
    .iniciar      (iniciar),
    .pausar       (pausar),
    .minutosZero  (minutosZero),
    .qUnidade     (qUnidade),
    .qDezena      (qDezena),
    .emprestimo   (emprestimo),
    .fim          (fim)
  );

  localparam int S_PARADO   = 0;
  localparam int S_CONTANDO = 1;
  localparam int S_PAUSADO  = 2;
  localparam int S_FIM      = 3;
  localparam int TOPO = MAX_DEZENA_DEF * 10 + MAX_UNIDADE_DEF;

  int mState = S_PARADO;
  int mCount = 0;
  int mPreset = 0;
  bit mEmp = 1'b0;
  bit mFim = 1'b0;
  bit prevEmp = 1'b0;
  int empPulses = 0;

  function automatic int clampi(int v, int m);
    return (v > m) ? m : v;
  endfunction

  // count held as plain seconds; the BCD digits are derived at check
  task automatic modelo();
    bit pulso;
    pulso = 1'b0;
    mEmp = 1'b0;
    if (clear) begin
      mState = S_PARADO;
      mCount = 0;
      mPreset = 0;
    end else if (carregar && mState != S_CONTANDO) begin
      mCount = clampi(int'(presetDezena), MAX_DEZENA_DEF) * 10
             + clampi(int'(presetUnidade), MAX_UNIDADE_DEF);
      mPreset = mCount;
      mState = S_PARADO;
    end else begin
      case (mState)
        S_CONTANDO: begin
          if (tick) begin
            if (mCount == 0 && minutosZero) begin
`ifdef RECARGA_AUTOMATICA_EN
              mCount = mPreset;
              pulso = 1'b1;
`else
              mState = S_FIM;
`endif
            end else if (mCount == 0) begin
              mCount = TOPO;
              mEmp = 1'b1;
            end else begin
              mCount = mCount - 1;
            end
          end
          if (pausar && mState == S_CONTANDO) mState = S_PAUSADO;
        end
        S_PARADO, S_PAUSADO: begin
          if (iniciar && !pausar) mState = S_CONTANDO;
        end
        default: ;
      endcase
    end
    mFim = (mState == S_FIM) || pulso;
  endtask

  task automatic chk(input string tag);
    logic [3:0] eu;
    logic [3:0] ed;
    eu = 4'(mCount % 10);
    ed = 4'(mCount / 10);
    checks++;
    assert (qUnidade === eu) else begin
      errors++;
      $error("FAIL %s qUnidade got %0d want %0d", tag, qUnidade, eu);
    end
    checks++;
    assert (qDezena === ed) else begin
      errors++;
      $error("FAIL %s qDezena got %0d want %0d", tag, qDezena, ed);
    end
    checks++;
    assert (emprestimo === mEmp) else begin
      errors++;
      $error("FAIL %s emprestimo got %b want %b", tag, emprestimo, mEmp);
    end
    checks++;
    assert (fim === mFim) else begin
      errors++;
      $error("FAIL %s fim got %b want %b", tag, fim, mFim);
    end
    checks++;
    assert (!(prevEmp && emprestimo === 1'b1)) else begin
      errors++;
      $error("FAIL %s emprestimo_twice got 1 want 0", tag);
    end
    prevEmp = (emprestimo === 1'b1);
    if (emprestimo === 1'b1) empPulses++;
  endtask

  task automatic confirma(input bit ok, input string tag,
                          input int got, input int want);
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic cyc(input bit c, input bit car, input bit tk,
                     input bit ini, input bit pau,
                     input logic [3:0] pu, input logic [3:0] pd,
                     input string tag);
    clear = c;
    carregar = car;
    tick = tk;
    iniciar = ini;
    pausar = pau;
    presetUnidade = pu;
    presetDezena = pd;
    @(posedge clk);
    modelo();
    #1;
    clear = 1'b0;
    carregar = 1'b0;
    tick = 1'b0;
    iniciar = 1'b0;
    pausar = 1'b0;
    chk(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 0, 4'd0, 4'd0, tag);
  endtask

  task automatic tk(input string tag);
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, tag);
    idle({tag, "_gap"});
  endtask

  task automatic carga(input logic [3:0] pd, input logic [3:0] pu,
                       input string tag);
    cyc(0, 1, 0, 0, 0, pu, pd, tag);
  endtask

  task automatic limpa(input string tag);
    cyc(1, 0, 0, 0, 0, 4'd0, 4'd0, tag);
  endtask

  task automatic inicia(input string tag);
    cyc(0, 0, 0, 1, 0, 4'd0, 4'd0, tag);
  endtask

  initial begin
    // reset and quiet period
    limpa("reset");
    confirma(dut.estado === PARADO, "reset_state",
             int'(dut.estado), int'(PARADO));
    idle("quiet1");
    idle("quiet2");

    // 3:5 countdown through the 00 -> 59 wrap
    minutosZero = 1'b0;
    carga(4'd3, 4'd5, "load35");
    inicia("start35");
    empPulses = 0;
    for (int i = 0; i < 36; i++) begin
      tk("conta35");
      if (i == 34)
        confirma(qDezena === 4'd0 && qUnidade === 4'd0,
                 "reach00", int'(qDezena) * 10 + int'(qUnidade), 0);
    end
    confirma(empPulses == 1, "borrow_once", empPulses, 1);
    confirma(qDezena === 4'd5 && qUnidade === 4'd9, "wrap59",
             int'(qDezena) * 10 + int'(qUnidade), 59);

    // 0:2 with minutes at zero reaches the end state
    limpa("clr2");
    carga(4'd0, 4'd2, "load02");
    inicia("start02");
    minutosZero = 1'b1;
    tk("fim_t1");
    tk("fim_t2");
    tk("fim_t3");
`ifndef RECARGA_AUTOMATICA_EN
    confirma(fim === 1'b1, "fim_high", int'(fim), 1);
`endif
    tk("fim_hold1");
    tk("fim_hold2");

    // clamp, pause, resume
    minutosZero = 1'b0;
    limpa("clr3");
    carga(4'd7, 4'hC, "load7C");
    confirma(qDezena === 4'd5 && qUnidade === 4'd9, "clamp59",
             int'(qDezena) * 10 + int'(qUnidade), 59);
    inicia("start59");
    tk("p_t1");
    tk("p_t2");
    cyc(0, 0, 0, 0, 1, 4'd0, 4'd0, "pausa");
    tk("paused1");
    tk("paused2");
    tk("paused3");
    confirma(qDezena === 4'd5 && qUnidade === 4'd7, "hold57",
             int'(qDezena) * 10 + int'(qUnidade), 57);
    inicia("resume");
    tk("r_t1");
    confirma(qDezena === 4'd5 && qUnidade === 4'd6, "resume56",
             int'(qDezena) * 10 + int'(qUnidade), 56);

    // load ignored while counting, then clear mid-count
    limpa("clr4");
    carga(4'd4, 4'd3, "load43");
    inicia("start43");
    tk("c_t1");
    carga(4'd1, 4'd1, "load_ignored");
    tk("c_t2");
    limpa("clr_mid");
    confirma(dut.estado === PARADO, "clr_state",
             int'(dut.estado), int'(PARADO));

`ifdef RECARGA_AUTOMATICA_EN
    // automatic reload of last preset
    carga(4'd0, 4'd1, "load01");
    minutosZero = 1'b1;
    inicia("start01");
    tk("a_t1");
    cyc(0, 0, 1, 0, 0, 4'd0, 4'd0, "a_reload");
    confirma(fim === 1'b1, "a_fim_pulse", int'(fim), 1);
    idle("a_after");
    confirma(dut.estado === CONTANDO, "a_state",
             int'(dut.estado), int'(CONTANDO));
    minutosZero = 1'b0;
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      minutosZero = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 59) == 0,
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 9) == 0,
          4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)),
          "random");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
